// File: rtl/ddr_axi_adapter.sv
// ddr_axi_adapter: AXI4 slave that arbitrates AW/AR onto one DDR command channel, splitting at row/FIFO limits.
// Optional DDR_ADAPTER_STATS_EN adds stat_split/stat_stall counters.
module ddr_axi_adapter #(
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 11,
    parameter int RFIFO_AW = 6,
    parameter int ADDR_W = ROW_BITS + COL_BITS + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [1:0]        s_awid,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wlast,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bid,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [1:0]        s_arid,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rid,
    output logic              s_rlast,
    output logic [1:0]        s_rresp,
    output logic              m_arw_valid,
    input  logic              m_arw_ready,
    output logic [ADDR_W-1:0] m_arw_addr,
    output logic [7:0]        m_arw_len,
    output logic              m_arw_write,
    output logic [1:0]        m_arw_id,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bid,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rid
`ifdef DDR_ADAPTER_STATS_EN
    ,
    output logic [15:0]       stat_split,
    output logic [15:0]       stat_stall
`endif
);
    localparam int RD = 1 << RFIFO_AW;
    localparam int ROW_WORDS = 1 << (COL_BITS - 1);
    localparam int CW = COL_BITS + 1;
    localparam int BW = CW > 9 ? CW : 9;
    localparam int CNTW = RFIFO_AW + 1;
    typedef enum logic [2:0] {IDLE, ISSUE, WDATA, WRESP, RWAIT} state_t;
    state_t state;
    logic [ADDR_W-1:0] addr;
    logic [8:0] rem;
    logic [1:0] id;
    logic dir, last_grant, trunc;
    logic [7:0] beat_cnt;
    logic [CNTW-1:0] cnt, free;
    logic [RFIFO_AW-1:0] wptr, rptr;
    logic [34:0] mem [RD];
    logic [BW-1:0] rem_b, left_b, cap_b, m1, beats;
    logic last_sub, lsub, credit_ok, gnt_w, gnt_r, wd, wr, wend, adv, push, pop;
    logic unused_bid;
    assign unused_bid = ^m_bid;
    assign rem_b = BW'(rem);
    assign left_b = BW'(ROW_WORDS) - BW'(addr[COL_BITS:2]);
    assign cap_b = dir ? BW'(256) : BW'(RD);
    assign m1 = rem_b < left_b ? rem_b : left_b;
    assign beats = m1 < cap_b ? m1 : cap_b;
    assign last_sub = beats == rem_b;
    assign lsub = last_sub || trunc;
    assign free = CNTW'(RD) - cnt;
    // reads only launch when the FIFO can absorb the whole sub-burst
    assign credit_ok = BW'(free) >= beats;
    assign gnt_w = state == IDLE && s_awvalid && (!s_arvalid || !last_grant);
    assign gnt_r = state == IDLE && s_arvalid && !gnt_w;
    assign s_awready = gnt_w;
    assign s_arready = gnt_r;
    assign m_arw_valid = state == ISSUE && (dir || credit_ok);
    assign m_arw_addr = state == ISSUE ? addr : '0;
    assign m_arw_len = state == ISSUE ? 8'(beats - BW'(1)) : '0;
    assign m_arw_write = state == ISSUE && dir;
    assign m_arw_id = state == ISSUE ? id : '0;
    assign wd = state == WDATA;
    assign s_wready = wd && m_wready;
    assign m_wvalid = wd && s_wvalid;
    assign m_wdata = wd ? s_wdata : '0;
    assign m_wstrb = wd ? s_wstrb : '0;
    assign wend = BW'(beat_cnt) == beats - BW'(1);
    assign m_wlast = wd && (wend || s_wlast);
    assign wr = state == WRESP;
    assign s_bvalid = wr && lsub && m_bvalid;
    assign m_bready = wr && (!lsub || s_bready);
    assign s_bid = wr && lsub ? id : '0;
    assign s_bresp = '0;
    assign adv = (wr && m_bvalid && m_bready) || (state == RWAIT && m_rvalid && m_rlast);
    assign push = state == RWAIT && m_rvalid;
    assign s_rvalid = cnt != '0;
    assign pop = s_rvalid && s_rready;
    assign {s_rid, s_rdata, s_rlast} = s_rvalid ? mem[rptr] : '0;
    assign s_rresp = '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr <= '0;
            rem <= '0;
            id <= '0;
            dir <= 1'b0;
            last_grant <= 1'b1;
            trunc <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_w || gnt_r) begin
                    addr <= (gnt_w ? s_awaddr : s_araddr) & ~ADDR_W'(3);
                    rem <= gnt_w ? 9'(s_awlen) + 9'd1 : 9'(s_arlen) + 9'd1;
                    id <= gnt_w ? s_awid : s_arid;
                    dir <= gnt_w;
                    last_grant <= gnt_w;
                    trunc <= 1'b0;
                    state <= ISSUE;
                end
                ISSUE: if (m_arw_valid && m_arw_ready) begin
                    beat_cnt <= '0;
                    state <= dir ? WDATA : RWAIT;
                end
                WDATA: if (m_wvalid && m_wready) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (m_wlast) begin
                        trunc <= s_wlast;
                        state <= WRESP;
                    end
                end
                WRESP, RWAIT: if (adv) begin
                    addr <= addr + ADDR_W'({beats, 2'b00});
                    rem <= rem - 9'(beats);
                    state <= lsub ? IDLE : ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt <= '0;
        end else begin
            if (push) wptr <= wptr + RFIFO_AW'(1);
            if (pop) rptr <= rptr + RFIFO_AW'(1);
            cnt <= cnt + CNTW'(push) - CNTW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {m_rid, m_rdata, m_rlast && last_sub};
    end
`ifdef DDR_ADAPTER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_split <= '0;
            stat_stall <= '0;
        end else begin
            if (m_arw_valid && m_arw_ready && !last_sub && stat_split != 16'hFFFF) stat_split <= stat_split + 16'd1;
            if (state == ISSUE && !dir && !credit_ok && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ddr_axi_adapter.sv
// tb_ddr_axi_adapter: scoreboard bench with a small DDR controller model behind the adapter.
module tb_ddr_axi_adapter;
    localparam int RD = 64;
    logic clk = 0, reset;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [26:0] s_awaddr, s_araddr, m_arw_addr;
    logic [7:0] s_awlen, s_arlen, m_arw_len;
    logic [1:0] s_awid, s_bid, s_bresp, s_arid, s_rid, s_rresp, m_arw_id, m_bid, m_rid;
    logic [31:0] s_wdata, s_rdata, m_wdata, m_rdata;
    logic [3:0] s_wstrb, m_wstrb;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic m_arw_valid, m_arw_ready, m_arw_write, m_wvalid, m_wready, m_wlast;
    logic m_bvalid, m_bready, m_rvalid, m_rlast;
`ifdef DDR_ADAPTER_STATS_EN
    logic [15:0] stat_split, stat_stall;
`endif
    int checks = 0, passes = 0, rpops = 0, arw_pops = 0;
    logic [37:0] exp_arw[$];
    logic [36:0] exp_w[$];
    logic [1:0] exp_b[$];
    logic [34:0] exp_r[$];

    always #5 clk = ~clk;

    ddr_axi_adapter dut (
        .clk(clk), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rlast(s_rlast), .s_rresp(s_rresp),
        .m_arw_valid(m_arw_valid), .m_arw_ready(m_arw_ready), .m_arw_addr(m_arw_addr), .m_arw_len(m_arw_len),
        .m_arw_write(m_arw_write), .m_arw_id(m_arw_id),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rid(m_rid)
`ifdef DDR_ADAPTER_STATS_EN
        , .stat_split(stat_split), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [31:0] rd_word(input logic [26:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic extra(input string nm, input logic [63:0] act);
        checks++;
        $display("FAIL %s: got %0h expected nothing", nm, act);
    endtask

    task automatic exp_cmd(input logic [26:0] a, input logic [7:0] l, input logic w, input logic [1:0] id);
        exp_arw.push_back({a, l, w, id});
    endtask

    task automatic write_txn(input logic [26:0] a, input logic [7:0] len, input logic [1:0] id,
                             input int n, input logic [7:0] mask);
        int t;
        for (int i = 0; i < n; i++) exp_w.push_back({32'hD000_0000 + 32'(a) + 32'(4 * i), 4'(15 - i), mask[i]});
        exp_b.push_back(id);
        @(posedge clk); #1;
        s_awvalid = 1; s_awaddr = a; s_awlen = len; s_awid = id;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_awready && t < 400);
        if (!s_awready) extra("aw_timeout", 64'(a));
        @(posedge clk); #1;
        s_awvalid = 0;
        for (int i = 0; i < n; i++) begin
            s_wvalid = 1; s_wdata = 32'hD000_0000 + 32'(a) + 32'(4 * i); s_wstrb = 4'(15 - i); s_wlast = (i == n - 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!s_wready && t < 400);
            if (!s_wready) extra("w_timeout", 64'(i));
            @(posedge clk); #1;
        end
        s_wvalid = 0; s_wlast = 0;
    endtask

    task automatic read_txn(input logic [26:0] a, input logic [7:0] len, input logic [1:0] id);
        int t;
        for (int i = 0; i <= int'(len); i++) exp_r.push_back({id, rd_word(a + 27'(4 * i)), i == int'(len)});
        @(posedge clk); #1;
        s_arvalid = 1; s_araddr = a; s_arlen = len; s_arid = id;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_arready && t < 400);
        if (!s_arready) extra("ar_timeout", 64'(a));
        @(posedge clk); #1;
        s_arvalid = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_arw.size() + exp_w.size() + exp_b.size() + exp_r.size()) != 0 && t < 3000) begin
            @(negedge clk); t++;
        end
        if (t >= 3000) extra("drain_timeout", 64'(exp_arw.size() + exp_w.size() + exp_b.size() + exp_r.size()));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // scoreboard monitors: commands, write responses, read beats
    always @(negedge clk) begin
        if (!reset) begin
            if (m_arw_valid && m_arw_ready) begin
                arw_pops = rpops;
                if (exp_arw.size() == 0) extra("arw_cmd", {m_arw_addr, m_arw_len, m_arw_write, m_arw_id});
                else chk("arw_cmd", {m_arw_addr, m_arw_len, m_arw_write, m_arw_id}, exp_arw.pop_front());
            end
            if (s_bvalid && s_bready) begin
                if (exp_b.size() == 0) extra("b_resp", {s_bid, s_bresp});
                else chk("b_resp", {s_bid, s_bresp}, {exp_b.pop_front(), 2'b00});
            end
            if (s_rvalid && s_rready) begin
                rpops++;
                if (exp_r.size() == 0) extra("r_beat", {s_rid, s_rdata, s_rlast, s_rresp});
                else chk("r_beat", {s_rid, s_rdata, s_rlast, s_rresp}, {exp_r.pop_front(), 2'b00});
            end
            if (dut.push && dut.cnt == 7'(RD)) extra("fifo_overflow_push", 64'(dut.cnt));
        end
    end

    // controller model: accepts commands, consumes write beats, returns read data
    initial begin
        logic [26:0] ca;
        logic [7:0] cl;
        logic [1:0] cid;
        logic cw, done;
        int t;
        m_arw_ready = 1; m_wready = 1; m_bvalid = 0; m_bid = 0;
        m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_rid = 0;
        forever begin
            @(negedge clk);
            if (!reset && m_arw_valid && m_arw_ready) begin
                ca = m_arw_addr; cl = m_arw_len; cid = m_arw_id; cw = m_arw_write;
                @(posedge clk); #1;
                if (cw) begin
                    t = 0; done = 0;
                    while (!done && !reset && t < 500) begin
                        @(negedge clk); t++;
                        if (m_wvalid && m_wready) begin
                            if (exp_w.size() == 0) extra("w_beat", {m_wdata, m_wstrb, m_wlast});
                            else chk("w_beat", {m_wdata, m_wstrb, m_wlast}, exp_w.pop_front());
                            done = m_wlast;
                        end
                    end
                    if (done) begin
                        @(posedge clk); #1;
                        m_bvalid = 1; m_bid = cid;
                        t = 0;
                        do begin @(negedge clk); t++; end while (!m_bready && !reset && t < 100);
                        @(posedge clk); #1;
                        m_bvalid = 0;
                    end
                end else begin
                    for (int i = 0; i <= int'(cl); i++) begin
                        if (reset) break;
                        m_rvalid = 1; m_rid = cid; m_rdata = rd_word(ca + 27'(4 * i)); m_rlast = (i == int'(cl));
                        @(posedge clk); #1;
                    end
                    m_rvalid = 0; m_rlast = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t, k, p0;
        logic [15:0] split0;
        reset = 1;
        s_awvalid = 0; s_awaddr = 0; s_awlen = 0; s_awid = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 1;
        s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arid = 0; s_rready = 1;
        split0 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arw_valid", m_arw_valid, 0);
        chk("rst_arw_addr", m_arw_addr, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        @(posedge clk); #1;
        reset = 0;
        // collision after reset: read wins, then write; next collision read wins again
        exp_cmd(27'h300, 1, 0, 2); exp_cmd(27'h200, 1, 1, 1);
        fork
            write_txn(27'h200, 1, 1, 2, 8'b10);
            read_txn(27'h300, 1, 2);
        join
        wait_done();
        exp_cmd(27'h500, 0, 0, 0); exp_cmd(27'h400, 0, 1, 3);
        fork
            write_txn(27'h400, 0, 3, 1, 8'b1);
            read_txn(27'h500, 0, 0);
        join
        wait_done();
        // plain 4-beat write
        exp_cmd(27'h100, 3, 1, 2);
        write_txn(27'h100, 3, 2, 4, 8'b1000);
        wait_done();
        // read crossing a row boundary
        exp_cmd(27'hFF8, 1, 0, 3); exp_cmd(27'h1000, 1, 0, 3);
        read_txn(27'hFF8, 3, 3);
        wait_done();
        // write crossing a row boundary, first response swallowed
        exp_cmd(27'hFFC, 0, 1, 1); exp_cmd(27'h1000, 0, 1, 1);
        write_txn(27'hFFC, 1, 1, 2, 8'b11);
        wait_done();
        // early wlast ends the transaction after the first sub-burst
        exp_cmd(27'hFFC, 0, 1, 0);
        write_txn(27'hFFC, 3, 0, 1, 8'b1);
        wait_done();
        // 256-beat read limited by FIFO credit
`ifdef DDR_ADAPTER_STATS_EN
        split0 = stat_split;
`endif
        s_rready = 0;
        p0 = rpops;
        exp_cmd(27'h0, 63, 0, 0); exp_cmd(27'h100, 63, 0, 0); exp_cmd(27'h200, 63, 0, 0); exp_cmd(27'h300, 63, 0, 0);
        read_txn(27'h0, 255, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("credit_stall", m_arw_valid, 0);
        chk("fifo_full_rvalid", s_rvalid, 1);
        chk("cmds_before_drain", exp_arw.size(), 3);
        @(posedge clk); #1;
        s_rready = 1;
        wait_done();
        chk("pops_before_last_cmd", arw_pops - p0, 192);
`ifdef DDR_ADAPTER_STATS_EN
        chk("stat_split", stat_split - split0, 3);
`endif
        // reset while read data is buffered
        s_rready = 0;
        exp_cmd(27'h2000, 19, 0, 1);
        read_txn(27'h2000, 19, 1);
        k = 0; t = 0;
        do begin @(negedge clk); if (m_rvalid) k++; t++; end while (k < 10 && t < 200);
        if (k < 10) extra("rbeat_timeout", 64'(k));
        @(posedge clk); #2;
        reset = 1;
        #1;
        chk("rst_mid_rvalid", s_rvalid, 0);
        exp_r.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_rvalid_hold", s_rvalid, 0);
        chk("rst_mid_cmd_left", exp_arw.size(), 0);
        reset = 0;
        s_rready = 1;
        exp_cmd(27'h40, 1, 0, 2);
        read_txn(27'h40, 1, 2);
        wait_done();
        chk("end_arw_q", exp_arw.size(), 0);
        chk("end_w_q", exp_w.size(), 0);
        chk("end_b_q", exp_b.size(), 0);
        chk("end_r_q", exp_r.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ddr_axi_adapter.md
Name: ddr_axi_adapter

Overview:
AXI4 slave front-end that sits directly upstream of the DDR SDRAM controller and drives its combined read/write command channel (m_arw_*).
- Arbitrates separate AW/AR channels onto that single channel.
- Splits bursts at DRAM row boundaries and at read-FIFO capacity.
- Buffers read data in a FIFO, because the controller's read path ignores backpressure.
- Merges sub-burst responses so the upstream master sees exactly one B or R burst per request.

Parameters:
ROW_BITS, 13, DRAM row address width
COL_BITS, 11, DRAM column width; one row holds 2^(COL_BITS-1) 32-bit words
RFIFO_AW, 6, log2 of read FIFO depth (depth RD = 2^RFIFO_AW, 4..256)
ADDR_W = ROW_BITS+COL_BITS+3, derived, byte address width

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high
s_awvalid/s_awready  in/out  1  write address handshake
s_awaddr  in  ADDR_W  byte address
s_awlen  in  8  beats-1
s_awid  in  2  ID
s_wvalid/s_wready  in/out  1  write data handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wlast  in  1  last write beat
s_bvalid/s_bready  out/in  1  write response handshake
s_bid  out  2  response ID
s_bresp  out  2  always 0 (OKAY)
s_arvalid/s_arready  in/out  1  read address handshake
s_araddr  in  ADDR_W  byte address
s_arlen  in  8  beats-1
s_arid  in  2  ID
s_rvalid/s_rready  out/in  1  read data handshake
s_rdata  out  32  read data
s_rid  out  2  read ID
s_rlast  out  1  last read beat
s_rresp  out  2  always 0
m_arw_valid/m_arw_ready  out/in  1  controller command handshake
m_arw_addr  out  ADDR_W  command byte address
m_arw_len  out  8  beats-1
m_arw_write  out  1  1=write
m_arw_id  out  2  command ID
m_wvalid/m_wready  out/in  1  controller write data handshake
m_wdata  out  32  write data
m_wstrb  out  4  byte strobes
m_wlast  out  1  last beat of sub-burst
m_bvalid/m_bready  in/out  1  controller write response handshake
m_bid  in  2  controller response ID
m_rvalid  in  1  controller read data valid
m_rlast  in  1  controller last read beat
m_rdata  in  32  controller read data
m_rid  in  2  controller read ID

Behaviour:
- Reset (async, active-high):
  - All valid/ready outputs 0; state IDLE.
  - FIFO empty; last_grant = WRITE.
  - Data, ID and address outputs 0.
- States: IDLE, ISSUE, WDATA, WRESP, RWAIT.
- IDLE:
  - Only one of s_awvalid/s_arvalid set: grant it.
  - Both set: grant opposite of last_grant.
  - Grant: s_awready or s_arready high for one cycle.
  - Latch addr with [1:0] forced to 0, rem = len+1, id, dir, final_seen=0.
  - Go to ISSUE.
- Sub-burst size: beats = min(rem, 2^(COL_BITS-1) - addr[COL_BITS:2], cap).
  - cap = RD for reads, 256 for writes.
  - m_arw_len = beats-1.
  - last_sub = (beats == rem).
- ISSUE:
  - m_arw_valid=1 with addr/len/dir/id.
  - Reads assert m_arw_valid only when FIFO free >= beats (credit stall otherwise).
  - On m_arw_ready: write goes to WDATA, read goes to RWAIT.
- WDATA:
  - s_wready=m_wready; m_wvalid=s_wvalid; data and strobes pass through combinationally.
  - m_wlast = (beat_cnt==beats-1) | s_wlast.
  - On the m_wlast beat, go to WRESP.
  - Early s_wlast truncates the whole transaction: treat as last_sub.
- WRESP:
  - Not last_sub: m_bready=1 and s_bvalid=0; the intermediate response is swallowed.
  - last_sub: s_bvalid=m_bvalid, m_bready=s_bready, s_bid=latched id.
  - On m_bvalid&m_bready: last_sub goes to IDLE; otherwise addr += beats*4, rem -= beats, go to ISSUE.
- RWAIT:
  - Every m_rvalid pushes {m_rid, m_rdata, m_rlast & last_sub} into the FIFO.
  - On m_rlast: advance as in WRESP, going to ISSUE or IDLE.
  - A push into a full FIFO is impossible by credit; the bench asserts on it.
- FIFO:
  - First-word-fall-through; s_rvalid = !empty.
  - Pop on s_rvalid&s_rready; simultaneous push and pop keep count unchanged.
  - Pointers wrap mod RD; count width RFIFO_AW+1.
- Address wrap: carry from column into row/bank is linear; top-of-memory wraps to 0.
- Write data is not buffered; W beats arriving before the AW grant wait (s_wready=0).

Optional Feature:
DDR_ADAPTER_STATS_EN:
- Defined: adds outputs stat_split[15:0] and stat_stall[15:0].
  - stat_split counts sub-bursts issued with !last_sub.
  - stat_stall counts ISSUE cycles blocked by read credit.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: no such ports or logic.

Test Plan:
- Write s_awaddr=0x100, awlen=3, 4 W beats -> one m_arw (0x100, len 3, write=1); m_wlast on beat 4; one s_bvalid with s_bid=awid.
- Read s_araddr=0x0FF8, arlen=3, COL_BITS=11 -> m_arw (0x0FF8, len 1) then (0x1000, len 1); 4 s_rdata beats in order; s_rlast only on beat 4.
- Read arlen=255, RFIFO_AW=6, s_rready=0 -> first m_arw len 63; second m_arw held until 64 pops; 4 sub-bursts total; stat_split=3 when enabled.
- Write awaddr=0x0FFC, awlen=1 -> two m_arw (len 0 each); first m_bvalid swallowed; exactly one s_bvalid.
- s_awvalid and s_arvalid both set right after reset -> read granted first, then write; on the next collision the read wins again because last_grant alternates.
- Reset asserted in RWAIT with 10 beats buffered -> s_rvalid=0 immediately, FIFO count=0, state IDLE, next request served normally.
